r_type_encoder: RTL and testbench
=================================

# r_type_encoder

Streaming RISC-V R-type instruction encoder: the inverse of the control unit's `alu_control` decode. It accepts an ALU operation code plus register indices over a valid/ready handshake and emits the matching 32-bit R-type instruction word (`opcode` = 7'b0110011) through a small output FIFO. It feeds program-image generation and decoder self-check benches, closing the encode→decode loop.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, at least 2.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  encoder can accept a request.
- `alu_control`  in  5  ALU operation code.
- `rd`, `rs1`, `rs2`  in  5 each  register indices.
- `out_valid`  out  1  FIFO head holds a word.
- `out_ready`  in  1  downstream takes the head word.
- `instr`  out  32  encoded word; 32'h0 whenever `out_valid`=0.
- `illegal`  out  1  one-cycle pulse: an accepted code had no R-type mapping.
- `word_count`  out  16  words popped since reset; wraps 16'hFFFF→0.

## Operation
- Code map (`alu_control` → `funct7`/`funct3`):
  - ADD 00000 → 0000000/000; SUB 00001 → 0100000/000; SLL 00010 → 0000000/001
  - SLT 00011 → 0000000/010; SLTU 00100 → 0000000/011; XOR 00101 → 0000000/100
  - OR 00110 → 0000000/110; AND 00111 → 0000000/111
  - SRL 01011 → 0000000/101; SRA 01100 → 0100000/101
  - Every other code is illegal.
- Word = {`funct7`, `rs2`, `rs1`, `funct3`, `rd`, 7'b0110011}. Register fields pass through unchanged; x0 is legal in every field.
- Accept: `in_valid` && `in_ready` at a rising edge.
  - Legal code: the word is pushed into the FIFO at that edge.
  - Illegal code: nothing is pushed; `illegal` is 1 in the following cycle only.
- Pop: `out_valid` && `out_ready` at a rising edge. The head advances and `word_count` increments.
- `in_ready` = !full, driven from the registered occupancy only. There is no combinational path from `out_ready`.
- Push and pop in the same edge: both take effect and occupancy is unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- Full: `in_ready`=0, so a new request is not accepted even if a pop occurs that cycle. `in_ready` rises the cycle after the pop.
- Empty: `out_valid`=0 and `instr`=0, and `out_ready` is ignored.

## Timing
- Latency: a word accepted at edge N is presented on `instr` with `out_valid`=1 in the cycle after edge N.
- Throughput: one word per cycle in steady state when downstream keeps `out_ready` high.
- While `rst` is high: `in_ready`=0, `out_valid`=0, `instr`=0, `illegal`=0, `word_count`=0.
- After reset, `in_ready`=1 in the first cycle with `rst` low.
- Reset mid-stream: all FIFO contents are discarded at that edge, with no partial word emitted. An accept coinciding with `rst`=1 is dropped.
- `illegal` and a legal push never coincide for the same request. Back-to-back illegal accepts give consecutive `illegal` pulses.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - the 5-bit `alu_control` code constants (ADD…SRA as above);
  - `OPC_RTYPE` = 7'b0110011;
  - the `funct7` constants 7'b0000000 and 7'b0100000.
- The control unit imports `alu_ctrl_pkg` as well, so decode and encode cannot drift apart.
- One sub-module, `r_type_lut`: combinational `alu_control` → {`legal`, `funct7`, `funct3`}.
- FIFO storage, pointers, occupancy and counter stay in `r_type_encoder`.

## Test plan
- ADD rd=3, rs1=1, rs2=2, `out_ready`=1 → `instr`=32'h002081B3, `out_valid`=1 one cycle after accept, `word_count`=1.
- SRA (01100) rd=5, rs1=6, rs2=7 → 32'h407352B3; SRL (01011) with the same registers → 32'h007352B3; SUB rd=1, rs1=2, rs2=3 → 32'h403100B3.
- Code 11111 → accepted, `illegal` pulses exactly one cycle, `out_valid` stays 0, `word_count` is unchanged.
- Hold `out_ready`=0 and push 4 legal requests (`FIFO_DEPTH`=4) → `in_ready`=0 after the 4th. A 5th request is held until one pop; `in_ready` rises the cycle after that pop. Words drain in order.
- Continuous push/pop for 65537 words → `word_count` wraps to 1. Assert `rst` with 3 words queued → next cycle `out_valid`=0, `instr`=0, `word_count`=0, `in_ready`=1 after `rst` deasserts.
- Randomized stream cross-checked by feeding `instr` back through the control unit: decoded `alu_control` equals the original for SRL and SRA.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU operation codes and R-type field constants, imported by both the
// control-unit decoder and the R-type encoder so the two mappings stay aligned.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00011;
  localparam logic [4:0] ALU_SLTU = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01011;
  localparam logic [4:0] ALU_SRA  = 5'b01100;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic       legal;
    logic [6:0] funct7;
    logic [2:0] funct3;
  } rtype_fields_t;

endpackage

// File: rtl/r_type_lut.sv
// Combinational map from alu_control to the R-type funct7/funct3 fields,
// flagging codes that have no R-type encoding.
module r_type_lut
  import alu_ctrl_pkg::*;
(
  input  logic [4:0]    alu_control,
  output rtype_fields_t fields
);

  always_comb begin
    fields = '{1'b0, F7_BASE, 3'b000};
    case (alu_control)
      ALU_ADD:  fields = '{1'b1, F7_BASE, 3'b000};
      ALU_SUB:  fields = '{1'b1, F7_ALT,  3'b000};
      ALU_SLL:  fields = '{1'b1, F7_BASE, 3'b001};
      ALU_SLT:  fields = '{1'b1, F7_BASE, 3'b010};
      ALU_SLTU: fields = '{1'b1, F7_BASE, 3'b011};
      ALU_XOR:  fields = '{1'b1, F7_BASE, 3'b100};
      ALU_OR:   fields = '{1'b1, F7_BASE, 3'b110};
      ALU_AND:  fields = '{1'b1, F7_BASE, 3'b111};
      ALU_SRL:  fields = '{1'b1, F7_BASE, 3'b101};
      ALU_SRA:  fields = '{1'b1, F7_ALT,  3'b101};
      default:  fields = '{1'b0, F7_BASE, 3'b000};
    endcase
  end

endmodule

// File: rtl/r_type_encoder.sv
// Streaming R-type instruction encoder: valid/ready request in, encoded 32-bit
// word out through a small FIFO, with an illegal-code pulse and a pop counter.
module r_type_encoder
  import alu_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  alu_control,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        illegal,
  output logic [15:0] word_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  rtype_fields_t    fields;
  logic [31:0]      word_p0;
  logic             accept, push, pop, full;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ;
  logic             illegal_p1;
  logic [15:0]      count_q;

  r_type_lut u_lut (
    .alu_control (alu_control),
    .fields      (fields)
  );

  // Stage p0: field assembly and handshake decisions
  assign word_p0 = {fields.funct7, rs2, rs1, fields.funct3, rd, OPC_RTYPE};
  assign full    = (occ == DEPTH_C);
  // Outputs are forced idle while rst is held, even before the reset edge lands.
  assign in_ready  = !rst && !full;
  assign out_valid = !rst && (occ != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && fields.legal;
  assign pop       = out_valid && out_ready;

  // Stage p1: FIFO storage (data path, not reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      illegal_p1 <= 1'b0;
      count_q    <= '0;
    end else begin
      illegal_p1 <= accept && !fields.legal;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        count_q <= count_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign instr      = out_valid ? mem[rd_ptr] : 32'h0;
  assign illegal    = !rst && illegal_p1;
  assign word_count = rst ? 16'h0 : count_q;

endmodule

// File: tb/tb_r_type_encoder.sv
// Self-checking bench for r_type_encoder: queue-based reference model compared
// every cycle, plus directed literal expectations and randomized traffic.
module tb_r_type_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_control = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic        illegal;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;

  r_type_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr       (instr),
    .illegal     (illegal),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  // Reference encoding straight from the code table.
  function automatic bit enc(input logic [4:0] c, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, output logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    bit ok;
    ok = 1'b1;
    f7 = 7'h00;
    f3 = 3'd0;
    case (c)
      5'd0:  f3 = 3'd0;
      5'd1:  begin f3 = 3'd0; f7 = 7'h20; end
      5'd2:  f3 = 3'd1;
      5'd3:  f3 = 3'd2;
      5'd4:  f3 = 3'd3;
      5'd5:  f3 = 3'd4;
      5'd6:  f3 = 3'd6;
      5'd7:  f3 = 3'd7;
      5'd11: f3 = 3'd5;
      5'd12: begin f3 = 3'd5; f7 = 7'h20; end
      default: ok = 1'b0;
    endcase
    w = {f7, s2, s1, f3, d, 7'h33};
    return ok;
  endfunction

  // Independent decoder standing in for the control unit; 5'h1F flags a bad word.
  function automatic logic [4:0] dec(input logic [31:0] w);
    logic [4:0] c;
    c = 5'h1F;
    if (w[6:0] == 7'h33 && w[29:25] == 5'd0 && w[31] == 1'b0) begin
      case ({w[30], w[14:12]})
        4'b0000: c = 5'd0;
        4'b1000: c = 5'd1;
        4'b0001: c = 5'd2;
        4'b0010: c = 5'd3;
        4'b0011: c = 5'd4;
        4'b0100: c = 5'd5;
        4'b0110: c = 5'd6;
        4'b0111: c = 5'd7;
        4'b0101: c = 5'd11;
        4'b1101: c = 5'd12;
        default: c = 5'h1F;
      endcase
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] mq[$];
  logic [4:0]  cq[$];
  bit          m_ill = 1'b0;
  logic [15:0] m_cnt = '0;
  bit          m_acc, m_pop;
  logic [31:0] m_w;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      cq.delete();
      m_ill = 1'b0;
      m_cnt = '0;
    end else begin
      m_acc = in_valid && (mq.size() < DEPTH);
      m_pop = (mq.size() > 0) && out_ready;
      if (m_pop) begin
        void'(mq.pop_front());
        void'(cq.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      m_ill = 1'b0;
      if (m_acc) begin
        if (enc(alu_control, rd, rs1, rs2, m_w)) begin
          mq.push_back(m_w);
          cq.push_back(alu_control);
        end else begin
          m_ill = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ew;
    ev = !rst && (mq.size() > 0);
    ew = ev ? mq[0] : 32'h0;
    chk("in_ready", {31'd0, in_ready}, {31'd0, !rst && (mq.size() < DEPTH)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("instr", instr, ew);
    chk("illegal", {31'd0, illegal}, {31'd0, !rst && m_ill});
    chk("word_count", {16'd0, word_count}, {16'd0, rst ? 16'h0 : m_cnt});
    if (ev) chk("decode_roundtrip", {27'd0, dec(instr)}, {27'd0, cq[0]});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [4:0] c, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2);
    in_valid = 1'b1; alu_control = c; rd = d; rs1 = s1; rs2 = s2;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic [4:0]  legal_codes [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd11, 5'd12};
  logic [31:0] tw;

  initial begin
    // Pin the model's encoding with hand-computed words
    chk("model_add", {31'd0, enc(5'd0, 5'd3, 5'd1, 5'd2, tw)}, 32'd1);
    chk("model_add_word", tw, 32'h002081B3);
    void'(enc(5'd12, 5'd5, 5'd6, 5'd7, tw));
    chk("model_sra_word", tw, 32'h407352B3);
    chk("model_illegal", {31'd0, enc(5'h1F, 5'd0, 5'd0, 5'd0, tw)}, 32'd0);

    cyc();
    cyc();
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD then directed literal words
    out_ready = 1'b1;
    cyc();
    req(5'd0, 5'd3, 5'd1, 5'd2);
    @(negedge clk);
    chk("add_instr", instr, 32'h002081B3);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    cyc();
    @(negedge clk);
    chk("add_count", {16'd0, word_count}, 32'd1);
    cyc();
    req(5'd12, 5'd5, 5'd6, 5'd7);
    @(negedge clk);
    chk("sra_instr", instr, 32'h407352B3);
    cyc();
    req(5'd11, 5'd5, 5'd6, 5'd7);
    @(negedge clk);
    chk("srl_instr", instr, 32'h007352B3);
    cyc();
    req(5'd1, 5'd1, 5'd2, 5'd3);
    @(negedge clk);
    chk("sub_instr", instr, 32'h403100B3);
    cyc();

    // Illegal code
    req(5'h1F, 5'd1, 5'd2, 5'd3);
    @(negedge clk);
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_no_valid", {31'd0, out_valid}, 32'd0);
    chk("ill_count", {16'd0, word_count}, 32'd4);
    cyc();
    @(negedge clk);
    chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
    cyc();

    // Fill with out_ready low, hold a 5th request until a pop
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) req(5'd0, i[4:0], 5'd0, 5'd0);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head", instr, 32'h000000B3);
    in_valid = 1'b1; alu_control = 5'd0; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0;
    cyc();
    cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("refill_in_ready", {31'd0, in_ready}, 32'd1);
    chk("second_head", instr, 32'h00000133);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) cyc();

    // Reset with 3 words queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) req(5'd7, 5'd9, 5'd10, i[4:0]);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_instr", instr, 32'h0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_count", {16'd0, word_count}, 32'd0);
    cyc();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      alu_control = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                : legal_codes[$urandom_range(0, 9)];
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    in_valid = 1'b0;

    // 65537 words through continuously; counter wraps to 1
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      alu_control = legal_codes[$urandom_range(0, 9)];
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("wrap_count", {16'd0, word_count}, 32'd1);
    chk("wrap_empty", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
